// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: PC, credit-limited fetch, response FIFO, ID output register
module if_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2,
  parameter logic [31:0] NOP_WORD   = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        id_stall,
  output logic        if_valid,
  output logic [31:0] if_ins,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc4
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int DW = 8;

  logic [31:0]   pc;
  logic [31:0]   buf_ins [FIFO_DEPTH];
  logic [31:0]   buf_pc  [FIFO_DEPTH];
  logic [AW-1:0] buf_wr, buf_rd;
  logic [CW-1:0] buf_cnt;
  // PCs of live in-flight requests; its occupancy is the outstanding count
  logic [31:0]   pcq [FIFO_DEPTH];
  logic [AW-1:0] pcq_wr, pcq_rd;
  logic [CW-1:0] outstanding;
  logic [DW-1:0] discard;

  logic [CW:0] in_use;
  logic        credit_ok, grant, live_rsp, push, load, pop;
  logic        unused_bits;

  assign in_use      = {1'b0, buf_cnt} + {1'b0, outstanding};
  assign credit_ok   = in_use < (CW+1)'(FIFO_DEPTH);
  assign imem_req    = rst & ~redirect & credit_ok;
  assign imem_addr   = pc;
  assign grant       = imem_req & imem_gnt;
  assign live_rsp    = imem_rvalid & (discard == '0);
  assign push        = live_rsp & ~redirect;
  assign load        = ~if_valid | ~id_stall;
  assign pop         = load & (buf_cnt != '0) & ~redirect;
  assign if_pc4      = if_pc + 32'd4;
  assign unused_bits = ^redirect_pc[1:0];

  always_ff @(posedge clk) begin
    if (grant) pcq[pcq_wr] <= pc;
    if (push) begin
      buf_ins[buf_wr] <= imem_rdata;
      buf_pc[buf_wr]  <= pcq[pcq_rd];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc          <= RESET_PC;
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      outstanding <= '0;
      discard     <= '0;
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_cnt     <= '0;
    end else if (redirect) begin
      // Everything still in flight becomes stale; a live word arriving now is dropped too
      pc          <= {redirect_pc[31:2], 2'b00};
      pcq_wr      <= '0;
      pcq_rd      <= '0;
      outstanding <= '0;
      discard     <= discard + DW'(outstanding) - DW'(imem_rvalid);
      buf_wr      <= '0;
      buf_rd      <= '0;
      buf_cnt     <= '0;
    end else begin
      if (grant) begin
        pc     <= pc + 32'd4;
        pcq_wr <= pcq_wr + AW'(1);
      end
      if (live_rsp) pcq_rd <= pcq_rd + AW'(1);
      outstanding <= outstanding + CW'(grant) - CW'(live_rsp);
      if (imem_rvalid && discard != '0) discard <= discard - DW'(1);
      if (push) buf_wr <= buf_wr + AW'(1);
      if (pop)  buf_rd <= buf_rd + AW'(1);
      buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if_valid <= 1'b0;
      if_ins   <= NOP_WORD;
      if_pc    <= 32'd0;
    end else if (redirect) begin
      if_valid <= 1'b0;
      if_ins   <= NOP_WORD;
    end else if (load) begin
      if (buf_cnt != '0) begin
        if_valid <= 1'b1;
        if_ins   <= buf_ins[buf_rd];
        if_pc    <= buf_pc[buf_rd];
      end else begin
        if_valid <= 1'b0;
        if_ins   <= NOP_WORD;
      end
    end
  end

`ifndef SYNTHESIS
  logic        prev_hold;
  logic [31:0] prev_addr;
  always_ff @(posedge clk) begin
    prev_hold <= imem_req & ~imem_gnt;
    prev_addr <= imem_addr;
    if (rst) begin
      assert (!(imem_rvalid && outstanding == '0 && discard == '0))
        else $error("imem_rvalid with nothing in flight");
      assert (!(prev_hold && imem_req) || imem_addr == prev_addr)
        else $error("imem_addr changed while request pending");
    end
  end
`endif
endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage with in-order variable-latency memory model
module tb_if_stage;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] NOP      = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, imem_req, imem_gnt, imem_rvalid, redirect, id_stall, if_valid;
  logic [31:0] imem_addr, imem_rdata, redirect_pc, if_ins, if_pc, if_pc4;

  if_stage #(.RESET_PC(RESET_PC), .FIFO_DEPTH(DEPTH), .NOP_WORD(NOP)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .redirect(redirect),
    .redirect_pc(redirect_pc), .id_stall(id_stall), .if_valid(if_valid), .if_ins(if_ins),
    .if_pc(if_pc), .if_pc4(if_pc4)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } rsp_t;
  typedef struct {
    logic [31:0] rpc;
    int          lat;
    logic [31:0] exp_addr;
    logic [31:0] exp_next;
    logic [31:0] exp_pc4;
  } vec_t;

  rsp_t        mq[$];
  vec_t        vecs[4];
  int          errors = 0, checks = 0, cyc = 0, last_due = 0;
  int          gnt_pct = 100, lat_min = 1, lat_max = 1;
  logic [31:0] exp_fetch, exp_pc, prev_pc, prev_ins;
  logic        prev_valid, prev_stall, prev_redirect;
  int          live_grants, presented, total_new, first_grant, first_valid;
  logic        s_new, s_req;
  logic [31:0] s_addr, s_pc, s_pc4;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: fetch addresses and presented PCs each form a contiguous +4 stream per redirect epoch
  task automatic observe();
    int due;
    s_new = 1'b0;
    if (prev_redirect) chk("redirect_flush_valid", if_valid, 0);
    else if (prev_valid && prev_stall) begin
      chk("hold_valid", if_valid, 1);
      chk("hold_pc", if_pc, prev_pc);
      chk("hold_ins", if_ins, prev_ins);
    end else if (if_valid) begin
      s_new = 1'b1;
      chk("out_pc", if_pc, exp_pc);
      chk("out_ins", if_ins, mem_word(exp_pc));
      chk("out_pc4", if_pc4, exp_pc + 32'd4);
      exp_pc = exp_pc + 32'd4;
      presented++;
      total_new++;
      if (first_valid < 0) first_valid = cyc;
    end
    chk("credit_bound", (live_grants - presented) <= DEPTH, 1);
    if (redirect) chk("req_in_redirect", imem_req, 0);
    if (imem_req) chk("fetch_addr", imem_addr, exp_fetch);
    s_req = imem_req; s_addr = imem_addr; s_pc = if_pc; s_pc4 = if_pc4;
    if (imem_req && imem_gnt) begin
      due = cyc + int'($urandom_range(lat_max, lat_min));
      if (due <= last_due) due = last_due + 1;
      last_due = due;
      mq.push_back('{imem_addr, due});
      exp_fetch = exp_fetch + 32'd4;
      live_grants++;
      if (first_grant < 0) first_grant = cyc;
    end
    if (imem_rvalid) void'(mq.pop_front());
    if (redirect) begin
      exp_fetch = {redirect_pc[31:2], 2'b00};
      exp_pc = exp_fetch;
      live_grants = 0; presented = 0; first_grant = -1; first_valid = -1;
    end
    prev_valid = if_valid; prev_stall = id_stall; prev_redirect = redirect;
    prev_pc = if_pc; prev_ins = if_ins;
  endtask

  task automatic cycle(input logic redir, input logic [31:0] rpc, input logic stall);
    imem_gnt = ($urandom_range(99) < gnt_pct);
    redirect = redir; redirect_pc = rpc; id_stall = stall;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1; imem_rdata = mem_word(mq[0].addr);
    end else begin
      imem_rvalid = 1'b0; imem_rdata = $urandom;
    end
    @(negedge clk);
    observe();
    @(posedge clk); #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst = 1'b0; redirect = 1'b0; imem_rvalid = 1'b0; id_stall = 1'b0; imem_gnt = 1'b1;
    redirect_pc = '0; imem_rdata = '0;
    @(negedge clk);
    chk("reset_req_comb", imem_req, 0);
    @(posedge clk); #1;
    cyc++;
    chk("reset_valid", if_valid, 0);
    chk("reset_ins", if_ins, NOP);
    chk("reset_pc", if_pc, 0);
    chk("reset_req", imem_req, 0);
    mq.delete(); last_due = cyc;
    exp_fetch = RESET_PC; exp_pc = RESET_PC;
    prev_valid = 0; prev_stall = 0; prev_redirect = 0;
    live_grants = 0; presented = 0; first_grant = -1; first_valid = -1;
    rst = 1'b1;
  endtask

  task automatic run_until_new(input string name);
    int n;
    n = 0;
    do begin
      cycle(1'b0, 32'd0, 1'b0);
      n++;
    end while (!s_new && n < 50);
    if (!s_new) chk({name, "_timeout"}, 0, 1);
  endtask

  initial begin
    int target, budget;
    rst = 1'b0;
    vecs[0] = '{32'h0000_0102, 3, 32'h0000_0100, 32'h0000_0104, 32'h0000_0104};
    vecs[1] = '{32'h1234_5677, 2, 32'h1234_5674, 32'h1234_5678, 32'h1234_5678};
    vecs[2] = '{32'hFFFF_FFFF, 1, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0000};
    vecs[3] = '{32'h8000_0001, 3, 32'h8000_0000, 32'h8000_0004, 32'h8000_0004};

    // Fixed 1-cycle memory, no stalls
    do_reset();
    for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, 1'b0);
    chk("first_valid_latency", first_valid - first_grant, 3);

    // Back-pressure: credits run out, outputs hold, stream stays contiguous afterwards
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'd0, 1'b1);
    chk("stall_req_dropped", s_req, 0);
    for (int i = 0; i < 10; i++) cycle(1'b0, 32'd0, 1'b0);

    // Redirect table: alignment, stale-response dropping, wrap
    for (int v = 0; v < 4; v++) begin
      do_reset();
      lat_min = vecs[v].lat; lat_max = vecs[v].lat;
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      cycle(1'b1, vecs[v].rpc, 1'b0);
      cycle(1'b0, 32'd0, 1'b0);
      chk($sformatf("v%0d_req", v), s_req, 1);
      chk($sformatf("v%0d_addr", v), s_addr, vecs[v].exp_addr);
      run_until_new($sformatf("v%0d_first", v));
      chk($sformatf("v%0d_first_pc", v), s_pc, vecs[v].exp_addr);
      chk($sformatf("v%0d_first_pc4", v), s_pc4, vecs[v].exp_pc4);
      run_until_new($sformatf("v%0d_second", v));
      chk($sformatf("v%0d_second_pc", v), s_pc, vecs[v].exp_next);
    end

    // Back-to-back redirects with stale responses accumulating
    lat_min = 3; lat_max = 3;
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h0000_0200, 1'b0);
    cycle(1'b0, 32'd0, 1'b0);
    cycle(1'b1, 32'h0000_0301, 1'b1);
    cycle(1'b1, 32'h0000_0402, 1'b0);
    run_until_new("b2b");
    chk("b2b_pc", s_pc, 32'h0000_0400);

    // Reset with work in flight and a full buffer
    lat_min = 2; lat_max = 2;
    for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 1'b1);
    do_reset();
    run_until_new("post_reset");
    chk("post_reset_pc", s_pc, RESET_PC);

    // Random grants, latency 1..3, stalls and occasional redirects
    gnt_pct = 60; lat_min = 1; lat_max = 3;
    target = total_new + 1000;
    budget = 0;
    while (total_new < target && budget < 30000) begin
      cycle($urandom_range(99) < 2, $urandom, $urandom_range(99) < 30);
      budget++;
    end
    chk("random_progress", total_new >= target, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
